// File: rtl/btn_gesture_ctrl.sv
// btn_gesture_ctrl: N-channel push-button front end.
// Per channel: 2-FF synchroniser, optional polarity inversion, tick-based
// debounce, and press / release / click / long-press one-shot detection.
// All timing is counted in i_tick periods (nominally 1 ms).
//
// Optional feature: define BTN_REPEAT_EN to enable auto-repeat pulses on
// o_repeat while a button stays held after o_long. Without the macro the
// repeat logic is not built and o_repeat is tied low.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   i_tick     one-clk strobe per timing tick
//   i_btn      raw asynchronous button pins (N_CH)
//   o_level    debounced level per channel, 1 = pressed
//   o_press    one-clk pulse on debounced press
//   o_release  one-clk pulse on every debounced release
//   o_click    one-clk pulse on release when o_long did not fire for that press
//   o_long     one-clk pulse once per press when the hold reaches LONG_MS ticks
//   o_repeat   one-clk auto-repeat pulses (BTN_REPEAT_EN only)
module btn_gesture_ctrl #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 500,
    parameter int unsigned REPEAT_MS   = 100,
    parameter int unsigned ACTIVE_LOW  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_tick,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_click,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_repeat
);

    localparam int unsigned HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    // Raw pin level that means "released"; also the synchroniser reset value.
    localparam logic [N_CH-1:0]   REL_LVL   = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_MS - 1);
`ifdef BTN_REPEAT_EN
    localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(REPEAT_MS - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    logic [N_CH-1:0]   sync1;
    logic [N_CH-1:0]   sync2;
    logic [N_CH-1:0]   s_c;
    logic [N_CH-1:0]   stable;
    logic [N_CH-1:0]   stable_q;
    logic [N_CH-1:0]   rise_c;
    logic [N_CH-1:0]   fall_c;
    logic [DB_W-1:0]   db_cnt   [N_CH];
    state_t            state    [N_CH];
    state_t            state_nxt[N_CH];
    logic [HOLD_W-1:0] hold     [N_CH];
    logic [HOLD_W-1:0] hold_nxt [N_CH];
    logic [N_CH-1:0]   press_nxt;
    logic [N_CH-1:0]   release_nxt;
    logic [N_CH-1:0]   click_nxt;
    logic [N_CH-1:0]   long_nxt;
`ifdef BTN_REPEAT_EN
    logic [N_CH-1:0]   repeat_nxt;
`endif

    // Two-flop synchroniser; reset to the released pin level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= REL_LVL;
            sync2 <= REL_LVL;
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
        end
    end

    // Normalise polarity so 1 always means pressed.
    assign s_c = sync2 ^ REL_LVL;

    // Debounce: a change must persist for DEBOUNCE_MS consecutive ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                db_cnt[i] <= '0;
            end
        end else if (i_tick) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (s_c[i] != stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= s_c[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Previous stable level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable;
        end
    end

    assign rise_c  = stable & ~stable_q;
    assign fall_c  = ~stable & stable_q;
    assign o_level = stable;

    // Gesture FSM state, hold counters and registered event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                state[i] <= ST_IDLE;
                hold[i]  <= '0;
            end
            o_press   <= '0;
            o_release <= '0;
            o_click   <= '0;
            o_long    <= '0;
`ifdef BTN_REPEAT_EN
            o_repeat  <= '0;
`endif
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                state[i] <= state_nxt[i];
                hold[i]  <= hold_nxt[i];
            end
            o_press   <= press_nxt;
            o_release <= release_nxt;
            o_click   <= click_nxt;
            o_long    <= long_nxt;
`ifdef BTN_REPEAT_EN
            o_repeat  <= repeat_nxt;
`endif
        end
    end

`ifndef BTN_REPEAT_EN
    assign o_repeat = '0;
`endif

    // Next-state and event decode; a release always beats a same-clk threshold.
    always_comb begin
        press_nxt   = '0;
        release_nxt = '0;
        click_nxt   = '0;
        long_nxt    = '0;
`ifdef BTN_REPEAT_EN
        repeat_nxt  = '0;
`endif
        for (int i = 0; i < int'(N_CH); i++) begin
            state_nxt[i] = state[i];
            hold_nxt[i]  = hold[i];
            case (state[i])
                ST_IDLE: begin
                    if (rise_c[i]) begin
                        state_nxt[i] = ST_PRESSED;
                        hold_nxt[i]  = '0;
                        press_nxt[i] = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (fall_c[i]) begin
                        state_nxt[i]   = ST_IDLE;
                        hold_nxt[i]    = '0;
                        release_nxt[i] = 1'b1;
                        click_nxt[i]   = 1'b1;
                    end else if (i_tick) begin
                        if (hold[i] == LONG_LAST) begin
                            state_nxt[i] = ST_LONG;
                            hold_nxt[i]  = '0;
                            long_nxt[i]  = 1'b1;
                        end else begin
                            hold_nxt[i] = hold[i] + HOLD_W'(1);
                        end
                    end
                end
                ST_LONG: begin
                    if (fall_c[i]) begin
                        state_nxt[i]   = ST_IDLE;
                        hold_nxt[i]    = '0;
                        release_nxt[i] = 1'b1;
                    end
`ifdef BTN_REPEAT_EN
                    else if (i_tick) begin
                        if (hold[i] == RPT_LAST) begin
                            hold_nxt[i]   = '0;
                            repeat_nxt[i] = 1'b1;
                        end else begin
                            hold_nxt[i] = hold[i] + HOLD_W'(1);
                        end
                    end
`endif
                end
                default: begin
                    state_nxt[i] = ST_IDLE;
                    hold_nxt[i]  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_gesture_ctrl.sv
// Scoreboard bench for btn_gesture_ctrl: an active-high instance (dut) and an
// active-low instance (dut_al). Stimulus pushes each expected event, with the
// exact tick index at which it must appear, into a per-instance queue; a
// monitor per instance pops and compares whenever any pulse output is high.
`timescale 1ns/1ps
module tb_btn_gesture_ctrl;

    localparam int unsigned N_CH = 4;
    localparam int          DB   = 20;
    localparam int          LNG  = 500;
    localparam int          RPT  = 100;

    typedef struct {
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] click;
        logic [3:0] lng;
        logic [3:0] rpt;
        int         tick;
    } ev_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       i_tick = 1'b0;
    logic [3:0] btn    = 4'h0;
    logic [3:0] btn_al = 4'hF;

    logic [3:0] o_level, o_press, o_release, o_click, o_long, o_repeat;
    logic [3:0] a_level, a_press, a_release, a_click, a_long, a_repeat;

    ev_t q0[$];
    ev_t q1[$];
    int  checks   = 0;
    int  errors   = 0;
    int  tick_idx = 0;

    btn_gesture_ctrl #(
        .N_CH(N_CH), .DEBOUNCE_MS(DB), .LONG_MS(LNG), .REPEAT_MS(RPT), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_btn(btn),
        .o_level(o_level), .o_press(o_press), .o_release(o_release),
        .o_click(o_click), .o_long(o_long), .o_repeat(o_repeat)
    );

    btn_gesture_ctrl #(
        .N_CH(N_CH), .DEBOUNCE_MS(DB), .LONG_MS(LNG), .REPEAT_MS(RPT), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_btn(btn_al),
        .o_level(a_level), .o_press(a_press), .o_release(a_release),
        .o_click(a_click), .o_long(a_long), .o_repeat(a_repeat)
    );

    always #5 clk = ~clk;

    // Tick strobe: one clk wide every 4 clks, changed 2 ns after the edge.
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #2;
            phase = (phase + 1) % 4;
            i_tick = (phase == 0);
            if (phase == 0) tick_idx++;
        end
    end

    function automatic ev_t mk(input logic [3:0] p, input logic [3:0] r, input logic [3:0] c,
                               input logic [3:0] l, input logic [3:0] rp, input int t);
        ev_t e;
        e.press = p; e.rel = r; e.click = c; e.lng = l; e.rpt = rp; e.tick = t;
        return e;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_ev(input string name, input ev_t exp, input ev_t got);
        checks++;
        if (got.press !== exp.press || got.rel !== exp.rel || got.click !== exp.click ||
            got.lng !== exp.lng || got.rpt !== exp.rpt || got.tick != exp.tick) begin
            errors++;
            $display("FAIL %s: got p=%b r=%b c=%b l=%b rp=%b tick=%0d, expected p=%b r=%b c=%b l=%b rp=%b tick=%0d",
                     name, got.press, got.rel, got.click, got.lng, got.rpt, got.tick,
                     exp.press, exp.rel, exp.click, exp.lng, exp.rpt, exp.tick);
        end
    endtask

    // Monitor for the active-high instance.
    initial begin
        ev_t got;
        forever begin
            @(posedge clk);
            #1;
            if (|{o_press, o_release, o_click, o_long, o_repeat}) begin
                got = mk(o_press, o_release, o_click, o_long, o_repeat, tick_idx);
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut_event_unexpected: got p=%b r=%b c=%b l=%b rp=%b tick=%0d, expected none",
                             got.press, got.rel, got.click, got.lng, got.rpt, got.tick);
                end else begin
                    check_ev("dut_event", q0.pop_front(), got);
                end
            end
        end
    end

    // Monitor for the active-low instance.
    initial begin
        ev_t got;
        forever begin
            @(posedge clk);
            #1;
            if (|{a_press, a_release, a_click, a_long, a_repeat}) begin
                got = mk(a_press, a_release, a_click, a_long, a_repeat, tick_idx);
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL al_event_unexpected: got p=%b r=%b c=%b l=%b rp=%b tick=%0d, expected none",
                             got.press, got.rel, got.click, got.lng, got.rpt, got.tick);
                end else begin
                    check_ev("al_event", q1.pop_front(), got);
                end
            end
        end
    end

    // Advance to the point just after the next tick strobe rises.
    task automatic next_tick(output int k);
        do begin
            @(posedge clk);
            #3;
        end while (!i_tick);
        k = tick_idx;
    endtask

    task automatic wait_ticks(input int n);
        int k;
        for (int j = 0; j < n; j++) next_tick(k);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int k2;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check_val("reset_outputs", 32'({o_level, o_press, o_release, o_click, o_long, o_repeat}), 32'h0);
        check_val("reset_outputs_al", 32'({a_level, a_press, a_release, a_click, a_long, a_repeat}), 32'h0);
        rst_n = 1'b1;
        wait_ticks(5);
        check_val("idle_level", 32'(o_level), 32'h0);
        check_val("idle_level_al", 32'(a_level), 32'h0);

        // Short press on ch0: press, then release with click.
        next_tick(k);
        btn[0] = 1'b1;
        q0.push_back(mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, k + DB));
        wait_ticks(25);
        check_val("s1_level_held", 32'(o_level), 32'h1);
        btn[0] = 1'b0;
        q0.push_back(mk(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, k + 25 + DB));
        wait_ticks(30);
        check_val("s1_level_rel", 32'(o_level), 32'h0);

        // Bounce on ch1 every 5 ticks: never reaches the debounce count.
        for (int j = 0; j < 40; j++) begin
            btn[1] = ~btn[1];
            wait_ticks(5);
            check_val("s2_level_bounce", 32'(o_level), 32'h0);
        end
        wait_ticks(30);

        // Long hold on ch2: press, long after 500 ticks, release without click.
        next_tick(k);
        btn[2] = 1'b1;
        q0.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, k + DB));
        q0.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, k + DB + LNG));
`ifdef BTN_REPEAT_EN
        q0.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, k + DB + LNG + RPT));
`endif
        wait_ticks(680);
        check_val("s3_level_held", 32'(o_level), 32'h4);
        btn[2] = 1'b0;
        q0.push_back(mk(4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, k + 680 + DB));
        wait_ticks(30);

        // Ch0 and ch3 together.
        next_tick(k);
        btn = 4'b1001;
        q0.push_back(mk(4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, k + DB));
        wait_ticks(30);
        check_val("s4_level_held", 32'(o_level), 32'h9);
        btn = 4'b0000;
        q0.push_back(mk(4'b0000, 4'b1001, 4'b1001, 4'b0000, 4'b0000, k + 30 + DB));
        wait_ticks(30);

        // Active-low instance: ch1 pin pulled low for 30 ticks.
        next_tick(k);
        btn_al[1] = 1'b0;
        q1.push_back(mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, k + DB));
        wait_ticks(30);
        check_val("s5_level_al_held", 32'(a_level), 32'h2);
        btn_al[1] = 1'b1;
        q1.push_back(mk(4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, k + 30 + DB));
        wait_ticks(30);
        check_val("s5_level_al_rel", 32'(a_level), 32'h0);

        // Reset while ch2 is in long-hold, button kept held through reset.
        next_tick(k);
        btn[2] = 1'b1;
        q0.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, k + DB));
        q0.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, k + DB + LNG));
        wait_ticks(540);
        check_val("s6_level_before_rst", 32'(o_level), 32'h4);
        rst_n = 1'b0;
        #1;
        check_val("s6_async_reset", 32'({o_level, o_press, o_release, o_click, o_long, o_repeat}), 32'h0);
        repeat (3) @(posedge clk);
        next_tick(k2);
        rst_n = 1'b1;
        q0.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, k2 + DB));
        wait_ticks(30);
        check_val("s6_level_repress", 32'(o_level), 32'h4);
        btn[2] = 1'b0;
        q0.push_back(mk(4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, k2 + 30 + DB));
        wait_ticks(30);

        check_val("dut_queue_drained", 32'(q0.size()), 32'h0);
        check_val("al_queue_drained", 32'(q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
